imem_loader_fetch: RTL and testbench

Parametrised instruction memory for the CPU front end, with a dedicated program-load port and a pipelined fetch port. A loader streams instruction words into the array with a valid/ready handshake and an auto-incrementing address. The fetch unit then reads one instruction per cycle with fixed one-cycle latency. A three-state controller (IDLE/LOAD/RUN) gates fetches until a program has been loaded.

---
 rtl/imem_loader_fetch.sv | 117 +++++++++++
 tb/tb_imem_loader_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_fetch.sv
// Instruction memory with a streaming program-load port and a 1-cycle fetch port.
// Optional per-word parity protection is enabled by defining IMEM_PARITY_EN.
module imem_loader_fetch #(
  parameter int unsigned INSTR_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic [ADDR_WIDTH-1:0]  load_base,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  input  logic                   parity_inject,
  output logic [ADDR_WIDTH:0]    load_count,
  output logic                   busy,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [INSTR_WIDTH-1:0] fetch_instr,
  output logic                   fetch_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = INSTR_WIDTH + 1;
`else
  localparam int unsigned MEM_W = INSTR_WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [MEM_W-1:0]      mem [DEPTH];
  logic [MEM_W-1:0]      wr_word;
  logic [MEM_W-1:0]      rd_word;
  logic                  rd_err;
  logic                  load_fire;
  logic                  fetch_fire;

  // A beat offered in a load_start cycle is dropped: the restart wins.
  assign load_ready = (state == S_LOAD) && !load_start;
  assign load_fire  = load_valid && load_ready;
  assign fetch_fire = fetch_req && (state == S_RUN);
  assign rd_word    = mem[fetch_addr];

`ifdef IMEM_PARITY_EN
  // Extra bit holds even parity of the data, optionally flipped for error injection.
  assign wr_word = {(^load_data) ^ parity_inject, load_data};
  assign rd_err  = ^rd_word;
`else
  logic unused_parity_inject;
  assign unused_parity_inject = parity_inject;
  assign wr_word = load_data;
  assign rd_err  = 1'b0;
`endif

  // Controller: IDLE -> LOAD on load_start, LOAD -> RUN on the last accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      load_count  <= '0;
      busy        <= 1'b0;
      fetch_ready <= 1'b0;
    end else begin
      if (load_start) begin
        state       <= S_LOAD;
        ptr         <= load_base;
        load_count  <= '0;
        busy        <= 1'b1;
        fetch_ready <= 1'b0;
      end else if (load_fire) begin
        ptr <= ptr + ADDR_WIDTH'(1);
        if (load_count != CNT_W'(DEPTH)) begin
          load_count <= load_count + CNT_W'(1);
        end
        if (load_last) begin
          state       <= S_RUN;
          busy        <= 1'b0;
          fetch_ready <= 1'b1;
        end
      end
    end
  end

  // Array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[ptr] <= wr_word;
    end
  end

  // Registered fetch response; instruction holds when no fetch is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_valid <= fetch_fire;
      fetch_err   <= fetch_fire && rd_err;
      if (fetch_fire) begin
        fetch_instr <= rd_word[INSTR_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader_fetch.sv
// Scoreboard bench for imem_loader_fetch: directed test-plan cases plus random traffic
// checked against an array/queue reference model.
module tb_imem_loader_fetch;

  localparam int unsigned IW    = 36;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
`ifdef IMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          parity_inject = 1'b0;
  logic [AW:0]   load_count;
  logic          busy;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [IW-1:0] fetch_instr;
  logic          fetch_err;

  always #5 clk = ~clk;

  imem_loader_fetch #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .parity_inject(parity_inject), .load_count(load_count), .busy(busy),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_err(fetch_err)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic          err;
    logic          known;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] m_mem [DEPTH];
  logic          m_bad [DEPTH];
  logic          m_wr  [DEPTH];
  logic          m_loading = 1'b0;
  logic          m_running = 1'b0;
  int            m_ptr = 0;
  int            m_count = 0;
  logic          e_busy = 1'b0;
  logic          e_fready = 1'b0;
  int            e_count = 0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: status against the model, fetch responses against the scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 64'(busy), 64'(e_busy));
      check("fetch_ready", 64'(fetch_ready), 64'(e_fready));
      check("load_count", 64'(load_count), 64'(e_count));
      check("load_ready", 64'(load_ready), 64'(e_busy && !load_start));
      if (fetch_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_fetch_valid at cycle %0d: got 1 expected 0", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("fetch_latency", 64'(cyc), 64'(e.due));
          if (e.known) check("fetch_instr", 64'(fetch_instr), 64'(e.instr));
          check("fetch_err", 64'(fetch_err), 64'(e.err));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        void'(exp_q.pop_front());
        checks++; failures++;
        $display("FAIL missing_fetch_valid at cycle %0d: got 0 expected 1", cyc);
      end
    end
  end

  // Apply the current inputs to the model, then advance one clock.
  task automatic cycle();
    if (fetch_req && m_running) begin
      exp_t e;
      e.instr = m_mem[fetch_addr];
      e.err   = PAR && m_bad[fetch_addr];
      e.known = m_wr[fetch_addr];
      e.due   = cyc + 1;
      exp_q.push_back(e);
    end
    if (load_start) begin
      m_loading = 1'b1; m_running = 1'b0; m_ptr = int'(load_base); m_count = 0;
    end else if (m_loading && load_valid) begin
      m_mem[m_ptr] = load_data;
      m_bad[m_ptr] = parity_inject;
      m_wr[m_ptr]  = 1'b1;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (m_count < DEPTH) m_count++;
      if (load_last) begin m_loading = 1'b0; m_running = 1'b1; end
    end
    @(posedge clk); #1;
    e_busy = m_loading; e_fready = m_running; e_count = m_count;
  endtask

  task automatic idle_inputs();
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    parity_inject = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic start_load(input logic [AW-1:0] base);
    idle_inputs(); load_start = 1'b1; load_base = base; cycle(); load_start = 1'b0;
  endtask

  task automatic beat(input logic [IW-1:0] d, input logic last, input logic inj);
    idle_inputs(); load_valid = 1'b1; load_data = d; load_last = last; parity_inject = inj;
    cycle();
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    idle_inputs(); fetch_req = 1'b1; fetch_addr = a; cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_ready"}, 64'(load_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_load_count"}, 64'(load_count), 64'd0);
    check({tag, "_fetch_ready"}, 64'(fetch_ready), 64'd0);
    check({tag, "_fetch_valid"}, 64'(fetch_valid), 64'd0);
    check({tag, "_fetch_instr"}, 64'(fetch_instr), 64'd0);
    check({tag, "_fetch_err"}, 64'(fetch_err), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_wr[i] = 1'b0; m_bad[i] = 1'b0; m_mem[i] = '0; end
    #2;
    check_all_zero("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch before any load is ignored.
    fetch(6'd0); fetch(6'd0);
    idle_inputs(); cycle();

    // Basic program at base 0, then back-to-back fetches.
    start_load(6'd0);
    beat(36'h011000010, 1'b0, 1'b0);
    beat(36'h012000020, 1'b0, 1'b0);
    beat(36'h052210000, 1'b0, 1'b0);
    beat(36'h030100030, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) fetch(AW'(i));
    idle_inputs(); cycle();

    // Pointer wrap from 63 to 0.
    start_load(6'd62);
    beat(36'hA0000000A, 1'b0, 1'b0);
    beat(36'hB0000000B, 1'b0, 1'b0);
    beat(36'hC0000000C, 1'b1, 1'b0);
    fetch(6'd62); fetch(6'd63); fetch(6'd0);

    // Fetch in the same cycle as a reload sees the old contents.
    idle_inputs(); fetch_req = 1'b1; fetch_addr = 6'd1; load_start = 1'b1; load_base = 6'd1;
    cycle();
    // Restart with a simultaneous beat: beat is dropped, count restarts.
    idle_inputs(); load_start = 1'b1; load_base = 6'd20; load_valid = 1'b1; load_data = 36'hDEADBEEF1;
    cycle();
    beat(36'h123456789, 1'b0, 1'b0);
    beat(36'h987654321, 1'b1, 1'b0);
    fetch(6'd20); fetch(6'd21); fetch(6'd1);

    // Parity: inject on addr 7 only.
    start_load(6'd6);
    beat(36'h0F0F0F0F0, 1'b0, 1'b0);
    beat(36'h0F0F0F0F1, 1'b1, 1'b1);
    fetch(6'd7); fetch(6'd6);

    // Saturating count: 66 beats starting at 10.
    start_load(6'd10);
    for (int i = 0; i < 66; i++) beat(IW'({$urandom(), $urandom()}), i == 65, 1'b0);
    fetch(6'd10); fetch(6'd11); fetch(6'd9);

    // Reset mid-load after 2 beats.
    start_load(6'd0);
    beat(36'h111111111, 1'b0, 1'b0);
    beat(36'h222222222, 1'b0, 1'b0);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check_all_zero("async_reset");
    m_loading = 1'b0; m_running = 1'b0; m_count = 0;
    e_busy = 1'b0; e_fready = 1'b0; e_count = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(6'd0);
    start_load(6'd5);
    beat(36'h555555555, 1'b1, 1'b0);
    fetch(6'd0); fetch(6'd1); fetch(6'd5);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      load_start    = ($urandom_range(0, 29) == 0);
      load_base     = AW'($urandom());
      load_valid    = ($urandom_range(0, 9) < 7);
      load_data     = IW'({$urandom(), $urandom()});
      load_last     = ($urandom_range(0, 7) == 0);
      parity_inject = ($urandom_range(0, 9) == 0);
      fetch_req     = ($urandom_range(0, 9) < 7);
      fetch_addr    = AW'($urandom());
      cycle();
    end
    idle_inputs(); cycle(); cycle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
